csr_initiator: RTL

CSR_INITIATOR -- requirements
Module: csr_initiator

---
 rtl/csr_initiator.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/csr_initiator.sv
// CSR access initiator: takes one read/write/set/clear request at a time,
// walks it through decode, execute and capture cycles on the CSR bus, and
// hands back the value the CSR held before any modification.
//
// state | meaning
// IDLE  | ready for a request; bus parked at IDLE_ADDR
// DEC   | address presented to the responders
// EXE   | modify/read/wdata presented for exactly one cycle
// CAP   | responders return old value and valid; captured at cycle end
// RSP   | response held until the requester takes it
module csr_initiator #(
   parameter logic [11:0] IDLE_ADDR = 12'h000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic        req_read,
   input  logic [11:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [11:0] csr_addr,
   output logic        csr_read,
   output logic [2:0]  csr_modify,
   output logic [31:0] csr_wdata,
   input  logic [31:0] csr_rdata,
   input  logic        csr_valid,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      DEC  = 3'd1,
      EXE  = 3'd2,
      CAP  = 3'd3,
      RSP  = 3'd4
   } state_t;

   state_t      state_q, state_d;

   logic [1:0]  op_q;
   logic        read_q;
   logic [31:0] wdata_q;

   logic [11:0] csr_addr_q, csr_addr_d;
   logic        csr_read_q, csr_read_d;
   logic [2:0]  csr_modify_q, csr_modify_d;
   logic [31:0] csr_wdata_q, csr_wdata_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;

   logic        accept;

   // A request is never taken while reset is asserted.
   assign req_ready = (state_q == IDLE) && !rst;
   assign accept    = req_valid && req_ready;
   assign busy      = (state_q != IDLE);

   assign csr_addr   = csr_addr_q;
   assign csr_read   = csr_read_q;
   assign csr_modify = csr_modify_q;
   assign csr_wdata  = csr_wdata_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: fixed walk through DEC/EXE/CAP, then wait for the handshake.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = DEC;
         DEC:     state_d = EXE;
         EXE:     state_d = CAP;
         CAP:     state_d = RSP;
         RSP:     if (resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output next-values, keyed on the state being entered so every bus and
   // response output comes straight from a flop.
   always_comb begin
      csr_addr_d   = IDLE_ADDR;
      csr_read_d   = 1'b0;
      csr_modify_d = 3'b000;
      csr_wdata_d  = 32'h0;
      resp_valid_d = (state_d == RSP);
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;

      // DEC is only entered from IDLE on accept, so the address comes from
      // the request port in the same cycle it is latched.
      if (state_d == DEC) begin
         csr_addr_d = req_addr;
      end

      if (state_d == EXE) begin
         csr_modify_d = {1'b0, op_q};
         csr_read_d   = read_q;
         csr_wdata_d  = wdata_q;
      end

      if (state_q == CAP) begin
         resp_rdata_d = csr_rdata;
         resp_err_d   = ~csr_valid;
      end
   end

   // Request latch and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q         <= 2'b00;
         read_q       <= 1'b0;
         wdata_q      <= 32'h0;
         csr_addr_q   <= IDLE_ADDR;
         csr_read_q   <= 1'b0;
         csr_modify_q <= 3'b000;
         csr_wdata_q  <= 32'h0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'h0;
         resp_err_q   <= 1'b0;
      end else begin
         if (accept) begin
            op_q    <= req_op;
            read_q  <= req_read;
            wdata_q <= req_wdata;
         end
         csr_addr_q   <= csr_addr_d;
         csr_read_q   <= csr_read_d;
         csr_modify_q <= csr_modify_d;
         csr_wdata_q  <= csr_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

endmodule
